// File: rtl/spi_slave_regs_if.sv
// SPI pins and register-write side-band of spi_slave_regs, bundled for port hookup.
interface spi_slave_regs_if;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic [7:0] STATUS;
  logic       REG_WE;
  logic [2:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       FRAME_DONE;

  modport slave (
    input  SCLK, CS, MOSI, STATUS,
    output MISO, REG_WE, REG_ADDR, REG_WDATA, FRAME_DONE
  );

  modport master (
    output SCLK, CS, MOSI, STATUS,
    input  MISO, REG_WE, REG_ADDR, REG_WDATA, FRAME_DONE
  );
endinterface

// File: rtl/spi_slave_regs.sv
// Mode-0 SPI slave with an 8-entry register file, oversampled entirely in the HCLK domain.
// Frame: command byte {R/W, 4'bx, addr[2:0]} followed by auto-incrementing data bytes.
module spi_slave_regs #(
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            HCLK,
  input  logic            HRESET,
  spi_slave_regs_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic [2:0] addr_q, addr_d;
  logic       read_q, read_d;
  logic [7:0] regs_q [2:7];
  logic [7:0] regs_d [2:7];
  logic       reg_we_q, reg_we_d;
  logic [2:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       frame_done_q, frame_done_d;

  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0] rx_next;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    cs_rise     = cs_s & ~cs_prev_q;
    cs_fall     = ~cs_s & cs_prev_q;
    rx_next     = {rx_q[6:0], mosi_s};
  end

  // Read mux: command completion loads the start address, data-byte completion the next one.
  always_comb begin
    rd_addr = (state_q == CMD) ? rx_next[2:0] : addr_q + 3'd1;
    rd_data = '0;
    case (rd_addr)
      3'd0:    rd_data = ID_VALUE;
      3'd1:    rd_data = bus.STATUS;
      default: rd_data = regs_q[rd_addr];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    miso_d       = miso_q;
    addr_d       = addr_q;
    read_d       = read_q;
    regs_d       = regs_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    frame_done_d = 1'b0;

    // CS edges take priority over any SCLK edge seen in the same cycle.
    if (cs_rise) begin
      state_d      = IDLE;
      miso_d       = 1'b0;
      frame_done_d = (state_q != IDLE);
    end else if (cs_fall) begin
      state_d   = CMD;
      bit_cnt_d = '0;
      rx_d      = '0;
      tx_d      = '0;
      miso_d    = 1'b0;
    end else if ((state_q != IDLE) && !cs_s) begin
      if (sclk_rise) begin
        rx_d      = rx_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == CMD) begin
            state_d = DATA;
            read_d  = rx_next[7];
            addr_d  = rx_next[2:0];
            tx_d    = rx_next[7] ? rd_data : '0;
          end else begin
            if (read_q) begin
              tx_d = rd_data;
            end else if (addr_q >= 3'd2) begin
              regs_d[addr_q] = rx_next;
              reg_we_d       = 1'b1;
              reg_addr_d     = addr_q;
              reg_wdata_d    = rx_next;
            end
            addr_d = addr_q + 3'd1;
          end
        end
      end else if (sclk_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      regs_q       <= '{default: '0};
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      miso_q       <= miso_d;
      addr_q       <= addr_d;
      read_q       <= read_d;
      regs_q       <= regs_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.MISO       = miso_q;
  assign bus.REG_WE     = reg_we_q;
  assign bus.REG_ADDR   = reg_addr_q;
  assign bus.REG_WDATA  = reg_wdata_q;
  assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed and random SPI frames against spi_slave_regs with write/read scoreboards.
module tb_spi_slave_regs;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  spi_slave_regs_if bus();

  spi_slave_regs #(.ID_VALUE(8'hA5), .SYNC_STAGES(2)) dut (
    .HCLK   (hclk),
    .HRESET (hreset),
    .bus    (bus)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  int         checks = 0;
  int         fails  = 0;
  int         we_cnt = 0;
  int         fd_cnt = 0;
  logic [7:0] model [8];
  wr_t        wq [$];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_reg(input logic [2:0] a);
    if (a == 3'd0) return 8'hA5;
    if (a == 3'd1) return bus.STATUS;
    return model[a];
  endfunction

  always @(negedge hclk) begin
    if (bus.FRAME_DONE === 1'b1) fd_cnt++;
    if (bus.REG_WE === 1'b1) begin
      we_cnt++;
      chk("we_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        wr_t w;
        w = wq.pop_front();
        chk("we_addr", 32'(bus.REG_ADDR), 32'(w.addr));
        chk("we_data", 32'(bus.REG_WDATA), 32'(w.data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge hclk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nb; i++) begin
      bus.MOSI = b[7-i];
      step(4);
      r = {r[6:0], bus.MISO};
      bus.SCLK = 1'b1;
      step(4);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic cs_low(input int extra);
    bus.CS = 1'b0;
    step(extra);
  endtask

  task automatic cs_high();
    step(4);
    bus.CS = 1'b1;
    step(8);
  endtask

  task automatic write_frame(input logic [2:0] a, input logic [7:0] d [4], input int n, input int extra);
    logic [7:0] r;
    logic [2:0] p;
    wr_t        w;
    p = a;
    cs_low(extra);
    spi_bits({5'b00000, a}, 8, r);
    for (int i = 0; i < n; i++) begin
      if (p >= 3'd2) begin
        w.addr = p;
        w.data = d[i];
        wq.push_back(w);
        model[p] = d[i];
      end
      spi_bits(d[i], 8, r);
      p = p + 3'd1;
    end
    cs_high();
  endtask

  task automatic read_frame(input logic [2:0] a, input int n, input int extra);
    logic [7:0] r;
    logic [7:0] e;
    logic [2:0] p;
    p = a;
    cs_low(extra);
    spi_bits({5'b10000, a}, 8, r);
    chk("cmd_miso_zero", 32'(r), 32'd0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_reg(p));
      spi_bits(8'($urandom), 8, r);
      e = exp_q.pop_front();
      chk("rd_data", 32'(r), 32'(e));
      p = p + 3'd1;
    end
    cs_high();
  endtask

  initial begin
    logic [7:0] d [4];
    logic [7:0] r;
    int         we0, fd0, n, extra;
    logic [2:0] a;

    bus.SCLK = 1'b0; bus.CS = 1'b1; bus.MOSI = 1'b0; bus.STATUS = 8'h00;
    hreset = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    step(3);
    chk("rst_miso", 32'(bus.MISO), 32'd0);
    chk("rst_we", 32'(bus.REG_WE), 32'd0);
    chk("rst_fd", 32'(bus.FRAME_DONE), 32'd0);
    chk("rst_addr", 32'(bus.REG_ADDR), 32'd0);
    chk("rst_wdata", 32'(bus.REG_WDATA), 32'd0);
    hreset = 1'b0;
    step(4);

    // single write to register 2
    we0 = we_cnt; fd0 = fd_cnt;
    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    write_frame(3'd2, d, 1, 0);
    chk("wr_we_count", 32'(we_cnt - we0), 32'd1);
    chk("wr_fd_count", 32'(fd_cnt - fd0), 32'd1);
    chk("wr_addr_held", 32'(bus.REG_ADDR), 32'd2);
    chk("wr_wdata_held", 32'(bus.REG_WDATA), 32'h3C);

    // read burst: ID, STATUS, register 2
    bus.STATUS = 8'h48;
    read_frame(3'd0, 3, 0);

    // wrap 7 -> 0 -> 1, only register 7 stored
    we0 = we_cnt;
    d = '{8'h11, 8'h22, 8'h33, 8'h00};
    write_frame(3'd7, d, 3, 0);
    chk("wrap_we_count", 32'(we_cnt - we0), 32'd1);
    read_frame(3'd7, 1, 0);

    // aborted partial data byte
    we0 = we_cnt; fd0 = fd_cnt;
    cs_low(0);
    spi_bits(8'h03, 8, r);
    spi_bits(8'hFF, 5, r);
    cs_high();
    chk("abort_we_count", 32'(we_cnt - we0), 32'd0);
    chk("abort_fd_count", 32'(fd_cnt - fd0), 32'd1);
    read_frame(3'd3, 1, 0);

    // CS rise coincident with the 8th SCLK rise
    we0 = we_cnt;
    cs_low(0);
    spi_bits(8'h04, 8, r);
    spi_bits(8'hAA, 7, r);
    bus.MOSI = 1'b0;
    step(4);
    bus.SCLK = 1'b1; bus.CS = 1'b1;
    step(4);
    bus.SCLK = 1'b0;
    step(8);
    chk("cswin_we_count", 32'(we_cnt - we0), 32'd0);
    read_frame(3'd4, 1, 0);

    // reset in the middle of a write data byte
    we0 = we_cnt;
    cs_low(0);
    spi_bits(8'h02, 8, r);
    spi_bits(8'h5A, 4, r);
    hreset = 1'b1;
    step(2);
    chk("mid_rst_miso", 32'(bus.MISO), 32'd0);
    chk("mid_rst_we", 32'(bus.REG_WE), 32'd0);
    chk("mid_rst_fd", 32'(bus.FRAME_DONE), 32'd0);
    chk("mid_rst_addr", 32'(bus.REG_ADDR), 32'd0);
    chk("mid_rst_wdata", 32'(bus.REG_WDATA), 32'd0);
    hreset = 1'b0;
    bus.CS = 1'b1;
    step(10);
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    chk("mid_rst_we_count", 32'(we_cnt - we0), 32'd0);
    read_frame(3'd2, 1, 0);

    // random frames
    for (int f = 0; f < 200; f++) begin
      a = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 3);
      extra = $urandom_range(0, 4);
      bus.STATUS = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        read_frame(a, n, extra);
      end else begin
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        write_frame(a, d, n, extra);
      end
    end

    step(4);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001: Parameter ID_VALUE, default 8'hA5, value returned by read-only register 0.
REQ-002: Parameter SYNC_STAGES, default 2, number of HCLK synchronizer flops on SCLK, CS and MOSI (minimum 2).
REQ-003: Port HCLK, input, 1, the only clock; all logic on its rising edge.
REQ-004: Port HRESET, input, 1, synchronous, active-high reset.
REQ-005: Port SCLK, input, 1, SPI clock from the master, asynchronous to HCLK, mode 0 (CPOL=0, CPHA=0).
REQ-006: Port CS, input, 1, active-low chip select from the master, asynchronous.
REQ-007: Port MOSI, input, 1, serial data from the master, MSB first.
REQ-008: Port MISO, output, 1, serial data to the master, MSB first.
REQ-009: Port STATUS, input, 8, live value returned by read-only register 1.
REQ-010: Port REG_WE, output, 1, one-HCLK pulse for each completed write data byte to registers 2..7.
REQ-011: Port REG_ADDR, output, 3, register address of the latest write, held until the next write.
REQ-012: Port REG_WDATA, output, 8, data of the latest write, held until the next write.
REQ-013: Port FRAME_DONE, output, 1, one-HCLK pulse when CS deasserts after an active frame.

Function
REQ-014: SCLK, CS and MOSI pass through SYNC_STAGES flops; SCLK edges are detected from the synchronized value and the previous synchronized value.
REQ-015: Supported SCLK frequency: at most HCLK/8; high and low phases each at least 4 HCLK periods.
REQ-016: FSM states: IDLE, CMD, DATA.
REQ-017: IDLE -> CMD on synchronized CS falling; bit counter cleared, rx shift cleared.
REQ-018: Each synchronized SCLK rising edge while CS low shifts the synchronized MOSI into rx shift LSB and increments a 3-bit bit counter.
REQ-019: CMD byte complete at the 8th rising edge: bit7 = R/W (1 = read), bits[2:0] = start address, bits[6:3] ignored; transition CMD -> DATA.
REQ-020: On CMD completion for a read, tx shift loads register[start address]; for a write, tx shift loads 8'h00.
REQ-021: Each synchronized SCLK falling edge while CS low drives MISO = tx shift[7] and shifts tx shift left by one, filling with 0.
REQ-022: MISO is 0 during the CMD byte and while CS is high.
REQ-023: DATA byte complete at each 8th rising edge: for a write, store rx byte to the current address; for a read, load tx shift with register[current address + 1]; then address increments by 1, wrapping 7 -> 0.
REQ-024: Register 0 reads ID_VALUE; register 1 reads STATUS as sampled in the load cycle; registers 2..7 read stored values.
REQ-025: Writes to addresses 0 and 1 are discarded: no REG_WE and no storage change; the address still increments.
REQ-026: A write to addresses 2..7 stores the byte and asserts REG_WE for exactly one cycle, with REG_ADDR and REG_WDATA updated in that same cycle.
REQ-027: Synchronized CS rising in any state -> IDLE; a partial byte is discarded with no store and no REG_WE.
REQ-028: FRAME_DONE pulses for one cycle on CS rising only from CMD or DATA.
REQ-029: If a CS rising and an SCLK edge are detected in the same cycle, CS wins and the edge is ignored.
REQ-030: CS falling while not in IDLE (glitch-free re-select) restarts at CMD.

Reset
REQ-031: While HRESET is high at an HCLK edge: state IDLE; MISO, REG_WE and FRAME_DONE = 0; REG_ADDR = 0; REG_WDATA = 0; registers 2..7 = 8'h00; counters and shift registers = 0; synchronizer flops: SCLK = 0, CS = 1, MOSI = 0.
REQ-032: HRESET asserted mid-frame aborts the frame with no store; after release, the block waits for a fresh CS falling edge.

Verification
REQ-033: Write frame: CS low, bytes 8'h02, 8'h3C; CS high -> one REG_WE pulse with REG_ADDR=2 and REG_WDATA=8'h3C; register 2=8'h3C; one FRAME_DONE pulse.
REQ-034: Read burst: with STATUS=8'h48, send 8'h80 then three dummy bytes -> MISO bytes are 8'hA5, 8'h48, 8'h3C.
REQ-035: Wrap: write 8'h07 then 8'h11, 8'h22, 8'h33 -> register 7=8'h11, register 0 write discarded (no REG_WE), register 1 write discarded, only one REG_WE in total; read 8'h87 then one dummy byte returns 8'h11.
REQ-036: Abort: send 8'h03 plus 5 bits of 8'hFF, then CS high -> no REG_WE, register 3 unchanged, FRAME_DONE=1 for one cycle.
REQ-037: HRESET pulse after 4 bits of a write data byte -> all outputs 0; a following read of register 2 returns 8'h00.
REQ-038: SCLK at HCLK/8 with random CS-to-SCLK spacing of 4 or more HCLK periods -> 200 random read/write frames match the scoreboard.
